// File: rtl/adler32_byte_feeder_if.sv
// rtl/adler32_byte_feeder_if.sv - frame-length and word-stream handshake bundle
interface adler32_byte_feeder_if;
  logic        frame_valid;
  logic [31:0] frame_len;
  logic        frame_ready;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;

  modport master (
    output frame_valid, frame_len, word_valid, word_data,
    input  frame_ready, word_ready
  );

  modport slave (
    input  frame_valid, frame_len, word_valid, word_data,
    output frame_ready, word_ready
  );
endinterface

// File: rtl/adler32_byte_feeder.sv
// rtl/adler32_byte_feeder.sv - word FIFO and byte serializer feeding the adler32 engine
module adler32_byte_feeder #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                        clock,
  input  logic                        rst,
  adler32_byte_feeder_if.slave        up,
  input  logic                        checksum_valid,
  output logic                        size_valid,
  output logic [31:0]                 size,
  output logic                        data_start,
  output logic [7:0]                  data,
  output logic                        underrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, PREFILL, SIZE_ST, START, STREAM, WAIT_DONE, GAP
  } state_t;

  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, fifo_count;
  logic          fifo_full, fifo_empty;
  logic [31:0]   len, byte_cnt, cur_word, drop_cnt;
  logic [GW-1:0] gap_cnt;
  logic          push, pop, stream_load, need_word, stream_pop, drop_pop, prefill_ok;
  logic [1:0]    lane;
  logic [31:0]   next_word, words_needed, count_ext;
  logic [7:0]    next_byte;

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);

  assign up.word_ready  = !rst && !fifo_full;
  assign up.frame_ready = !rst && (state == IDLE) && (drop_cnt == 32'd0);
  assign push = up.word_valid && up.word_ready;

  // ceil(len/4) without overflowing for len near 2^32
  assign words_needed = {2'b00, len[31:2]} + {31'd0, |len[1:0]};
  assign count_ext    = 32'(fifo_count);
  assign prefill_ok   = fifo_full || (count_ext >= words_needed);

  assign lane        = byte_cnt[1:0];
  assign stream_load = (state == START) || ((state == STREAM) && (byte_cnt != len));
  assign need_word   = stream_load && (lane == 2'd0);
  assign stream_pop  = need_word && !fifo_empty;
  assign drop_pop    = (drop_cnt != 32'd0) && (state != STREAM) && (state != START) && !fifo_empty;
  assign pop         = stream_pop || drop_pop;

  // An empty FIFO at a word boundary zero-fills the whole slot
  always_comb begin
    next_word = cur_word;
    if (need_word) next_word = fifo_empty ? 32'd0 : mem[rd_ptr[AW-1:0]];
    next_byte = next_word[{lane, 3'b000} +: 8];
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= up.word_data;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      len        <= 32'd0;
      byte_cnt   <= 32'd0;
      cur_word   <= 32'd0;
      drop_cnt   <= 32'd0;
      gap_cnt    <= '0;
      size_valid <= 1'b0;
      size       <= 32'd0;
      data_start <= 1'b0;
      data       <= 8'd0;
      underrun   <= 1'b0;
    end else begin
      size_valid <= 1'b0;
      data_start <= 1'b0;
      if (push)     wr_ptr   <= wr_ptr + 1'b1;
      if (pop)      rd_ptr   <= rd_ptr + 1'b1;
      if (drop_pop) drop_cnt <= drop_cnt - 32'd1;
      case (state)
        IDLE: begin
          if (up.frame_valid && up.frame_ready) begin
            len <= up.frame_len;
            if (up.frame_len != 32'd0) state <= PREFILL;
          end
        end
        PREFILL: begin
          if (prefill_ok) begin
            state      <= SIZE_ST;
            size_valid <= 1'b1;
            size       <= len;
          end
        end
        SIZE_ST: begin
          state      <= START;
          data_start <= 1'b1;
          byte_cnt   <= 32'd0;
        end
        START, STREAM: begin
          if (stream_load) begin
            state    <= STREAM;
            data     <= next_byte;
            cur_word <= next_word;
            byte_cnt <= byte_cnt + 32'd1;
            if (need_word && fifo_empty) begin
              underrun <= 1'b1;
              drop_cnt <= drop_cnt + 32'd1;
            end
          end else begin
            data  <= 8'd0;
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (checksum_valid) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adler32_byte_feeder.sv
// tb/tb_adler32_byte_feeder.sv - directed self-checking bench for adler32_byte_feeder
module tb_adler32_byte_feeder;
  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        checksum_valid = 1'b0;
  logic        size_valid, data_start, underrun;
  logic [31:0] size;
  logic [7:0]  data;

  adler32_byte_feeder_if up_if();

  adler32_byte_feeder #(.FIFO_DEPTH(8), .GAP_CYCLES(1)) dut (
    .clock(clock),
    .rst(rst),
    .up(up_if),
    .checksum_valid(checksum_valid),
    .size_valid(size_valid),
    .size(size),
    .data_start(data_start),
    .data(data),
    .underrun(underrun)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         sv_cnt = 0, ds_cnt = 0, done_cnt = 0, overlap = 0;
  int         sv_cyc = 0, ds_cyc = 0, cap_len = 0, csum_cyc = 0;
  logic [31:0] sv_size = 32'd0;
  logic [7:0] tail = 8'd0;
  logic       cap_on = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  // Engine-side observer: records pulses and the byte run that follows data_start
  always @(negedge clock) begin
    if (rst) begin
      cap_on = 1'b0;
    end else begin
      if (size_valid) begin
        sv_cnt++; sv_cyc = cyc; sv_size = size; cap_len = int'(size);
      end
      if (size_valid && data_start) overlap++;
      if (cap_on) begin
        if (got.size() < cap_len) got.push_back(data);
        else begin tail = data; cap_on = 1'b0; done_cnt++; end
      end
      if (data_start) begin
        ds_cnt++; ds_cyc = cyc; cap_on = 1'b1; got.delete();
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    int t = 0;
    up_if.word_valid = 1'b1;
    up_if.word_data  = w;
    @(negedge clock);
    while (!up_if.word_ready && t < 500) begin @(negedge clock); t++; end
    check("word_hs", 32'(up_if.word_ready), 32'd1);
    @(posedge clock); #1;
    up_if.word_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] len);
    int t = 0;
    up_if.frame_valid = 1'b1;
    up_if.frame_len   = len;
    @(negedge clock);
    while (!up_if.frame_ready && t < 500) begin @(negedge clock); t++; end
    check("frame_hs", 32'(up_if.frame_ready), 32'd1);
    @(posedge clock); #1;
    up_if.frame_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] len, input string tag);
    int d0 = done_cnt;
    int t = 0;
    send_frame(len);
    while (done_cnt == d0 && t < 2000) begin @(posedge clock); #1; t++; end
    check({tag, "_done"}, 32'(done_cnt != d0), 32'd1);
    if (done_cnt != d0) begin
      check({tag, "_size"}, sv_size, len);
      check({tag, "_start_lat"}, 32'(ds_cyc - sv_cyc), 32'd1);
      check({tag, "_nbytes"}, 32'(got.size()), len);
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
        check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
      check({tag, "_tail"}, 32'(tail), 32'd0);
    end
    csum_cyc = cyc;
    checksum_valid = 1'b1;
    @(posedge clock); #1;
    checksum_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int prev_csum, sv0, ds0, t;
    logic [31:0] w;
    up_if.frame_valid = 1'b0; up_if.frame_len = 32'd0;
    up_if.word_valid  = 1'b0; up_if.word_data = 32'd0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_size_valid", 32'(size_valid), 32'd0);
    check("rst_data_start", 32'(data_start), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_size", size, 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_frame_ready", 32'(up_if.frame_ready), 32'd0);
    check("rst_word_ready", 32'(up_if.word_ready), 32'd0);
    rst = 1'b0;
    @(posedge clock); #1;
    check("idle_word_ready", 32'(up_if.word_ready), 32'd1);
    check("idle_frame_ready", 32'(up_if.frame_ready), 32'd1);

    // 1: len 5, two words, upper lanes of the last word discarded
    push_word(32'h44332211);
    push_word(32'h000000AA);
    exp_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    run_frame(32'd5, "t1");
    check("t1_underrun", 32'(underrun), 32'd0);

    // 2: zero-length frame is dropped and leaves the FIFO alone
    push_word(32'hD4C3B2A1);
    sv0 = sv_cnt; ds0 = ds_cnt;
    send_frame(32'd0);
    repeat (10) @(posedge clock);
    #1;
    check("t2_no_size_valid", 32'(sv_cnt), 32'(sv0));
    check("t2_no_data_start", 32'(ds_cnt), 32'(ds0));
    exp_q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_frame(32'd4, "t2");

    // 3: back-to-back frames respect the post-checksum gap
    push_word(32'h0D0C0B0A);
    push_word(32'h1D1C1B1A);
    exp_q = {8'h0A, 8'h0B, 8'h0C, 8'h0D};
    run_frame(32'd4, "t3a");
    prev_csum = csum_cyc;
    exp_q = {8'h1A, 8'h1B, 8'h1C, 8'h1D};
    run_frame(32'd4, "t3b");
    check("t3_gap_ok", 32'((sv_cyc - prev_csum) >= 4), 32'd1);

    // 5: full FIFO back-pressures, nothing lost, order kept
    exp_q.delete();
    for (int k = 0; k < 9; k++) begin
      w = 32'h50505050 + 32'h01010101 * k;
      add_word(w);
      if (k < 8) push_word(w);
    end
    up_if.word_valid = 1'b1;
    up_if.word_data  = 32'h58585858;
    repeat (4) @(posedge clock);
    #1;
    check("t5_full_ready", 32'(up_if.word_ready), 32'd0);
    fork
      push_word(32'h58585858);
      run_frame(32'd36, "t5");
    join

    // 4: word 8 of a 40-byte frame arrives late
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      w = 32'h03020100 + 32'h04040404 * k;
      add_word(w);
      push_word(w);
    end
    add_word(32'h0);
    add_word(32'h23222120);
    ds0 = ds_cnt;
    fork
      run_frame(32'd40, "t4");
      begin
        t = 0;
        while (!(ds_cnt != ds0 && got.size() >= 33) && t < 1000) begin
          @(posedge clock); #1; t++;
        end
        check("t4_late_wait", 32'(t < 1000), 32'd1);
        push_word(32'h23222120);
      end
    join
    check("t4_underrun", 32'(underrun), 32'd1);
    push_word(32'hDEADBEEF);
    push_word(32'h87654321);
    exp_q = {8'h21, 8'h43, 8'h65, 8'h87};
    run_frame(32'd4, "t4n");
    check("t4n_underrun_sticky", 32'(underrun), 32'd1);

    // 6: reset mid-stream flushes the FIFO
    push_word(32'h33221100);
    push_word(32'h77665544);
    ds0 = ds_cnt;
    up_if.frame_valid = 1'b1;
    up_if.frame_len   = 32'd8;
    t = 0;
    while (!(ds_cnt != ds0 && got.size() >= 4) && t < 500) begin
      @(posedge clock); #1; t++;
      if (ds_cnt != ds0) up_if.frame_valid = 1'b0;
    end
    up_if.frame_valid = 1'b0;
    check("t6_reached_b3", 32'(got.size() >= 4), 32'd1);
    rst = 1'b1;
    @(posedge clock); #1;
    check("t6_size_valid", 32'(size_valid), 32'd0);
    check("t6_data_start", 32'(data_start), 32'd0);
    check("t6_data", 32'(data), 32'd0);
    check("t6_size", size, 32'd0);
    check("t6_underrun", 32'(underrun), 32'd0);
    check("t6_frame_ready", 32'(up_if.frame_ready), 32'd0);
    check("t6_word_ready", 32'(up_if.word_ready), 32'd0);
    rst = 1'b0;
    @(posedge clock); #1;
    check("t6_fifo_empty", 32'(up_if.word_ready), 32'd1);
    push_word(32'hCCBBAA99);
    exp_q = {8'h99, 8'hAA, 8'hBB, 8'hCC};
    run_frame(32'd4, "t6n");

    check("no_overlap", 32'(overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
